// File: rtl/feature_stream_padder_if.sv
// feature_stream_padder_if
//   Stream bundle for the feature padder.
//   Input side : in_data (one pixel, CH_PER_GROUP channels), in_valid/in_ready (one bit per group).
//   Output side: out_data (all group lanes), out_valid/out_ready, plus the beat sidebands
//                out_win_valid, out_last, out_row and out_col.
//   master : producer/consumer side (drives inputs, accepts the output stream).
//   slave  : the padder itself.
interface feature_stream_padder_if #(
  parameter int unsigned FEATURE_WIDTH = 8,
  parameter int unsigned CH_PER_GROUP  = 8,
  parameter int unsigned GROUP_NUM     = 2,
  parameter int unsigned DIM_W         = 10
);
  localparam int unsigned GW = CH_PER_GROUP * FEATURE_WIDTH;

  logic [GW-1:0]           in_data;
  logic [GROUP_NUM-1:0]    in_valid;
  logic [GROUP_NUM-1:0]    in_ready;
  logic [GROUP_NUM*GW-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_win_valid;
  logic                    out_last;
  logic [DIM_W:0]          out_row;
  logic [DIM_W:0]          out_col;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_win_valid, out_last, out_row, out_col
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_win_valid, out_last, out_row, out_col
  );
endinterface

// File: rtl/feature_stream_padder.sv
// feature_stream_padder
//   Buffers raw pixels for up to GROUP_NUM channel groups in per-group show-ahead FIFOs and
//   streams the zero/constant padded feature map in raster order through a registered
//   valid/ready output. Beats that complete a strided KxK window are flagged.
// Ports
//   system_clk, rst_n      : clock, asynchronous active-low reset
//   load_begin             : flush all FIFOs and abort any stream in progress
//   compute_begin          : start one map with the configuration sampled in the same cycle
//   compute_done           : one-cycle pulse after the final beat is accepted
//   busy                   : high while a map is in flight
//   row_size/col_size      : unpadded map size
//   pad_size/pad_value     : border width on every side and the value emitted there
//   kernel_size            : K of the KxK window
//   stride_log2            : window stride 1/2/4 (3 behaves as 2)
//   group_num              : number of active channel groups
//   bus                    : input pixel stream and padded output stream with sidebands
module feature_stream_padder #(
  parameter int unsigned FEATURE_WIDTH = 8,
  parameter int unsigned CH_PER_GROUP  = 8,
  parameter int unsigned GROUP_NUM     = 2,
  parameter int unsigned FIFO_DEPTH    = 512,
  parameter int unsigned DIM_W         = 10
) (
  input  logic                               system_clk,
  input  logic                               rst_n,
  input  logic                               load_begin,
  input  logic                               compute_begin,
  output logic                               compute_done,
  output logic                               busy,
  input  logic [DIM_W-1:0]                   row_size,
  input  logic [DIM_W-1:0]                   col_size,
  input  logic [2:0]                         pad_size,
  input  logic [FEATURE_WIDTH-1:0]           pad_value,
  input  logic [2:0]                         kernel_size,
  input  logic [1:0]                         stride_log2,
  input  logic [$clog2(GROUP_NUM+1)-1:0]     group_num,
  feature_stream_padder_if.slave             bus
);
  localparam int unsigned GW   = CH_PER_GROUP * FEATURE_WIDTH;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = DIM_W + 1;
  localparam int unsigned GN_W = $clog2(GROUP_NUM + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_e;

  // ---------------- per-group FIFOs ----------------
  logic [GW-1:0]        mem_q     [GROUP_NUM][FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q  [GROUP_NUM];
  logic [AW:0]          wr_ptr_d  [GROUP_NUM];
  logic [AW:0]          rd_ptr_q  [GROUP_NUM];
  logic [AW:0]          rd_ptr_d  [GROUP_NUM];
  logic [GW-1:0]        head      [GROUP_NUM];
  logic [GROUP_NUM-1:0] full, empty, push, pop;

  always_comb begin
    for (int unsigned g = 0; g < GROUP_NUM; g++) begin
      // Extra pointer bit distinguishes full from empty when the indices match.
      full[g]  = (wr_ptr_q[g] ^ rd_ptr_q[g]) == {1'b1, {AW{1'b0}}};
      empty[g] = (wr_ptr_q[g] == rd_ptr_q[g]);
      head[g]  = mem_q[g][rd_ptr_q[g][AW-1:0]];
    end
  end

  assign push         = bus.in_valid & ~full;
  assign bus.in_ready = ~full;

  always_comb begin
    for (int unsigned g = 0; g < GROUP_NUM; g++) begin
      wr_ptr_d[g] = wr_ptr_q[g] + (AW+1)'(push[g]);
      rd_ptr_d[g] = rd_ptr_q[g] + (AW+1)'(pop[g]);
      if (load_begin) begin
        wr_ptr_d[g] = '0;
        rd_ptr_d[g] = '0;
      end
    end
  end

  always_ff @(posedge system_clk) begin
    for (int unsigned g = 0; g < GROUP_NUM; g++) begin
      if (push[g]) mem_q[g][wr_ptr_q[g][AW-1:0]] <= bus.in_data;
    end
  end

  // ---------------- stream control ----------------
  state_e                   state_q, state_d;
  logic [2:0]               pad_q, pad_d;
  logic [FEATURE_WIDTH-1:0] pad_value_q, pad_value_d;
  logic [2:0]               k_q, k_d;
  logic [1:0]               stride_q, stride_d;
  logic [GN_W-1:0]          gn_q, gn_d;
  logic [DIM_W-1:0]         rows_q, rows_d, cols_q, cols_d;
  logic [CW-1:0]            pr_q, pr_d, pc_q, pc_d;
  logic [CW-1:0]            row_q, row_d, col_q, col_d;
  logic [GROUP_NUM*GW-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_win_q, out_win_d;
  logic                     out_last_q, out_last_d;
  logic [CW-1:0]            out_row_q, out_row_d, out_col_q, out_col_d;
  logic                     done_q, done_d;

  logic [GROUP_NUM-1:0] active;
  logic                 data_rdy, is_pad, ld, take, win, at_last;
  logic [CW-1:0]        pad_ext, k_m1, smask;

  always_comb begin
    for (int unsigned g = 0; g < GROUP_NUM; g++) active[g] = (g < 32'(gn_q));
    data_rdy = &(~empty | ~active);
    pad_ext  = CW'(pad_q);
    k_m1     = CW'(k_q) - CW'(1);
    case (stride_q)
      2'd0:    smask = '0;
      2'd1:    smask = CW'(1);
      default: smask = CW'(3);
    endcase
    is_pad  = (row_q < pad_ext) || (row_q >= pad_ext + CW'(rows_q)) ||
              (col_q < pad_ext) || (col_q >= pad_ext + CW'(cols_q));
    win     = (row_q >= k_m1) && (col_q >= k_m1) &&
              (((row_q - k_m1) & smask) == '0) && (((col_q - k_m1) & smask) == '0);
    at_last = (row_q == pr_q - CW'(1)) && (col_q == pc_q - CW'(1));
    ld      = ~out_valid_q | bus.out_ready;
    take    = ld & (is_pad | data_rdy);
  end

  always_comb begin
    state_d     = state_q;
    pad_d       = pad_q;
    pad_value_d = pad_value_q;
    k_d         = k_q;
    stride_d    = stride_q;
    gn_d        = gn_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    pr_d        = pr_q;
    pc_d        = pc_q;
    row_d       = row_q;
    col_d       = col_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_win_d   = out_win_q;
    out_last_d  = out_last_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    done_d      = 1'b0;
    pop         = '0;

    case (state_q)
      ST_IDLE: begin
        if (compute_begin) begin
          pad_d       = pad_size;
          pad_value_d = pad_value;
          k_d         = kernel_size;
          stride_d    = stride_log2;
          gn_d        = group_num;
          rows_d      = row_size;
          cols_d      = col_size;
          pr_d        = CW'(row_size) + CW'({pad_size, 1'b0});
          pc_d        = CW'(col_size) + CW'({pad_size, 1'b0});
          row_d       = '0;
          col_d       = '0;
          state_d     = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (take) begin
          out_valid_d = 1'b1;
          out_row_d   = row_q;
          out_col_d   = col_q;
          out_win_d   = win;
          out_last_d  = at_last;
          for (int unsigned g = 0; g < GROUP_NUM; g++) begin
            if (!active[g])  out_data_d[g*GW +: GW] = '0;
            else if (is_pad) out_data_d[g*GW +: GW] = {CH_PER_GROUP{pad_value_q}};
            else             out_data_d[g*GW +: GW] = head[g];
          end
          if (!is_pad) pop = active;
          if (col_q == pc_q - CW'(1)) begin
            col_d = '0;
            row_d = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (at_last) state_d = ST_DONE;
        end else if (ld) begin
          // Prior beat consumed but no data ready: present a bubble.
          out_valid_d = 1'b0;
          out_win_d   = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          out_win_d   = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_begin) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_win_d   = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
      pop         = '0;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pad_q       <= '0;
      pad_value_q <= '0;
      k_q         <= '0;
      stride_q    <= '0;
      gn_q        <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      pr_q        <= '0;
      pc_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_win_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      done_q      <= 1'b0;
      for (int unsigned g = 0; g < GROUP_NUM; g++) begin
        wr_ptr_q[g] <= '0;
        rd_ptr_q[g] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pad_q       <= pad_d;
      pad_value_q <= pad_value_d;
      k_q         <= k_d;
      stride_q    <= stride_d;
      gn_q        <= gn_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      pr_q        <= pr_d;
      pc_q        <= pc_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_win_q   <= out_win_d;
      out_last_q  <= out_last_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign bus.out_data      = out_data_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_win_valid = out_win_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_row       = out_row_q;
  assign bus.out_col       = out_col_q;
  assign compute_done      = done_q;
  assign busy              = (state_q != ST_IDLE);
endmodule

// File: tb/tb_feature_stream_padder.sv
module tb_feature_stream_padder;
  localparam int unsigned FW = 8, CPG = 8, GN = 2, DEPTH = 512, DW = 10;
  localparam int unsigned GW = FW * CPG;
  localparam int unsigned OW = GN * GW;

  logic          system_clk = 1'b0;
  logic          rst_n = 1'b0, load_begin = 1'b0, compute_begin = 1'b0;
  logic          compute_done, busy;
  logic [DW-1:0] row_size = '0, col_size = '0;
  logic [2:0]    pad_size = '0, kernel_size = 3'd1;
  logic [FW-1:0] pad_value = '0;
  logic [1:0]    stride_log2 = '0;
  logic [1:0]    group_num = 2'd1;

  int unsigned checks = 0, errors = 0;
  int unsigned cyc = 0;

  feature_stream_padder_if #(.FEATURE_WIDTH(FW), .CH_PER_GROUP(CPG), .GROUP_NUM(GN), .DIM_W(DW)) bus ();

  feature_stream_padder #(
    .FEATURE_WIDTH(FW), .CH_PER_GROUP(CPG), .GROUP_NUM(GN), .FIFO_DEPTH(DEPTH), .DIM_W(DW)
  ) dut (
    .system_clk   (system_clk),
    .rst_n        (rst_n),
    .load_begin   (load_begin),
    .compute_begin(compute_begin),
    .compute_done (compute_done),
    .busy         (busy),
    .row_size     (row_size),
    .col_size     (col_size),
    .pad_size     (pad_size),
    .pad_value    (pad_value),
    .kernel_size  (kernel_size),
    .stride_log2  (stride_log2),
    .group_num    (group_num),
    .bus          (bus)
  );

  always #5 system_clk = ~system_clk;
  always @(posedge system_clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    logic [DW:0]   row;
    logic [DW:0]   col;
    logic          win;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         e, hold_b;
  logic [GW-1:0] px [GN][DEPTH];
  int unsigned   beats = 0, wins = 0, done_cnt = 0, last_cyc = 0;
  bit            hold_pending = 0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer, stall-stability and done-timing monitor.
  always @(negedge system_clk) begin
    if (hold_pending) begin
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_data", bus.out_data, hold_b.data);
      check("hold_side", {bus.out_row, bus.out_col, bus.out_win_valid, bus.out_last},
            {hold_b.row, hold_b.col, hold_b.win, hold_b.last});
    end
    hold_pending = 0;
    if (bus.out_valid && bus.out_ready) begin
      check("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", bus.out_data, e.data);
        check("beat_coord", {bus.out_row, bus.out_col}, {e.row, e.col});
        check("beat_flags", {bus.out_win_valid, bus.out_last}, {e.win, e.last});
      end
      beats++;
      if (bus.out_win_valid) wins++;
      if (bus.out_last) last_cyc = cyc;
    end else if (bus.out_valid) begin
      hold_pending = 1;
      hold_b.data = bus.out_data;
      hold_b.row  = bus.out_row;
      hold_b.col  = bus.out_col;
      hold_b.win  = bus.out_win_valid;
      hold_b.last = bus.out_last;
    end
    if (compute_done) begin
      done_cnt++;
      check("done_latency", cyc, last_cyc + 1);
    end
  end

  task automatic gen_px(input int g, input int n);
    for (int i = 0; i < n; i++) px[g][i] = {$urandom, $urandom};
  endtask

  task automatic feed(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_data  = px[g][i];
      bus.in_valid = GN'(1) << g;
      @(posedge system_clk); #1;
    end
    bus.in_valid = '0;
  endtask

  task automatic build_exp(input int rows, input int cols, input int pad, input int pv,
                           input int k, input int s, input int gn);
    int pr, pc, m;
    beat_t b;
    bit ispad;
    pr = rows + 2 * pad;
    pc = cols + 2 * pad;
    m  = (s == 3) ? 4 : (1 << s);
    for (int r = 0; r < pr; r++) begin
      for (int c = 0; c < pc; c++) begin
        ispad  = (r < pad) || (r >= pad + rows) || (c < pad) || (c >= pad + cols);
        b.data = '0;
        for (int g = 0; g < gn; g++)
          b.data[g*GW +: GW] = ispad ? {CPG{8'(pv)}} : px[g][(r - pad) * cols + (c - pad)];
        b.row  = (DW+1)'(r);
        b.col  = (DW+1)'(c);
        b.win  = (r >= k - 1) && (c >= k - 1) && ((r - k + 1) % m == 0) && ((c - k + 1) % m == 0);
        b.last = (r == pr - 1) && (c == pc - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic start_map(input int rows, input int cols, input int pad, input int pv,
                           input int k, input int s, input int gn);
    build_exp(rows, cols, pad, pv, k, s, gn);
    row_size      = DW'(rows);
    col_size      = DW'(cols);
    pad_size      = 3'(pad);
    pad_value     = FW'(pv);
    kernel_size   = 3'(k);
    stride_log2   = 2'(s);
    group_num     = 2'(gn);
    compute_begin = 1'b1;
    @(posedge system_clk); #1;
    compute_begin = 1'b0;
  endtask

  task automatic finish_map(input string tag, input int nbeats, input int nwins,
                            input int unsigned b0, input int unsigned w0,
                            input int unsigned d0, input bit bp);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge system_clk); #1;
    end
    bus.out_ready = 1'b1;
    check({tag, "_timeout"}, ok, 1'b1);
    repeat (3) @(posedge system_clk); #1;
    check({tag, "_beats"}, beats - b0, nbeats);
    check({tag, "_wins"}, wins - w0, nwins);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic run_map(input string tag, input int rows, input int cols, input int pad,
                         input int pv, input int k, input int s, input int gn,
                         input int nwins, input bit bp, input bit chk_lat);
    int unsigned b0, w0, d0;
    b0 = beats; w0 = wins; d0 = done_cnt;
    start_map(rows, cols, pad, pv, k, s, gn);
    if (chk_lat) begin
      @(negedge system_clk);
      check({tag, "_lat1"}, bus.out_valid, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      @(negedge system_clk);
      check({tag, "_lat2"}, bus.out_valid, 1'b1);
      @(posedge system_clk); #1;
    end
    finish_map(tag, (rows + 2 * pad) * (cols + 2 * pad), nwins, b0, w0, d0, bp);
  endtask

  initial begin
    int unsigned b0, w0, d0;
    bit ok;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge system_clk);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_flags", {bus.out_win_valid, bus.out_last, compute_done, busy}, 4'b0);
    check("rst_data", bus.out_data, '0);
    check("rst_coord", {bus.out_row, bus.out_col}, '0);
    check("rst_in_ready", bus.in_ready, 2'b11);
    @(posedge system_clk); #1;
    rst_n = 1'b1;
    @(posedge system_clk); #1;

    // T1: 4x4 pad 1, K=3 stride 1
    gen_px(0, 16); feed(0, 16);
    run_map("t1", 4, 4, 1, 8'hA5, 3, 0, 1, 16, 0, 1);

    // T2: same with stride 2
    gen_px(0, 16); feed(0, 16);
    run_map("t2", 4, 4, 1, 8'h3C, 3, 1, 1, 4, 0, 1);

    // T3: two groups, group 1 arrives late
    gen_px(0, 9); gen_px(1, 9); feed(0, 9);
    b0 = beats; w0 = wins; d0 = done_cnt;
    fork
      start_map(3, 3, 0, 0, 3, 0, 2);
      begin
        repeat (5) begin
          @(negedge system_clk);
          check("t3_no_early_beat", bus.out_valid, 1'b0);
        end
        @(posedge system_clk); #1;
        feed(1, 9);
      end
    join
    finish_map("t3", 9, 1, b0, w0, d0, 0);

    // T4: T1 under random backpressure
    gen_px(0, 16); feed(0, 16);
    run_map("t4", 4, 4, 1, 8'h5A, 3, 0, 1, 16, 1, 0);

    // T5: fill to depth, a single pop frees a slot
    gen_px(0, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("t5_ready_before_full", bus.in_ready[0], 1'b1);
      bus.in_data  = px[0][i];
      bus.in_valid = 2'b01;
      @(posedge system_clk); #1;
    end
    bus.in_valid = '0;
    @(negedge system_clk);
    check("t5_full", bus.in_ready, 2'b10);
    @(posedge system_clk); #1;
    b0 = beats; w0 = wins; d0 = done_cnt;
    start_map(1, 1, 0, 0, 1, 0, 1);
    @(negedge system_clk);
    check("t5_still_full", bus.in_ready[0], 1'b0);
    @(negedge system_clk);
    check("t5_ready_after_pop", bus.in_ready[0], 1'b1);
    @(posedge system_clk); #1;
    finish_map("t5", 1, 1, b0, w0, d0, 0);
    load_begin = 1'b1;
    @(posedge system_clk); #1;
    load_begin = 1'b0;
    @(negedge system_clk);
    check("t5_flush_ready", bus.in_ready, 2'b11);
    @(posedge system_clk); #1;

    // T6: abort at beat 10, then a clean rerun
    gen_px(0, 16); feed(0, 16);
    b0 = beats; d0 = done_cnt;
    start_map(4, 4, 1, 8'h77, 3, 0, 1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (beats - b0 >= 10) begin ok = 1; break; end
      @(posedge system_clk); #1;
    end
    check("t6_reach_beat10", ok, 1'b1);
    load_begin = 1'b1;
    @(posedge system_clk); #1;
    load_begin = 1'b0;
    @(negedge system_clk);
    check("t6_abort_valid", bus.out_valid, 1'b0);
    check("t6_abort_busy", busy, 1'b0);
    check("t6_abort_ready", bus.in_ready, 2'b11);
    exp_q.delete();
    repeat (5) @(posedge system_clk); #1;
    check("t6_no_done", done_cnt - d0, 0);
    gen_px(0, 16); feed(0, 16);
    run_map("t6_rerun", 4, 4, 1, 8'h77, 3, 0, 1, 16, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
